// File: rtl/id_ex_fwd_stage_if.sv
// ID/EX stage bundle: decoded ID fields and MEM producer info in, latched EX fields out.
interface id_ex_fwd_stage_if #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned REG_W  = 5,
  parameter int unsigned CNT_W  = 16
);
  logic              flush;
  logic              id_valid;
  logic [REG_W-1:0]  id_rs;
  logic [REG_W-1:0]  id_rt;
  logic [REG_W-1:0]  id_rd;
  logic [DATA_W-1:0] id_rs_data;
  logic [DATA_W-1:0] id_rt_data;
  logic [DATA_W-1:0] id_imm;
  logic              id_alusrc;
  logic              id_uses_rt;
  logic              id_reg_write;
  logic              id_mem_read;
  logic              id_mem_write;
  logic [3:0]        id_alu_op;
  logic [REG_W-1:0]  mem_rd;
  logic              mem_reg_write;

  logic              stall;
  logic              ex_valid;
  logic [DATA_W-1:0] ex_rs_data;
  logic [DATA_W-1:0] ex_rt_data;
  logic [DATA_W-1:0] ex_imm;
  logic [REG_W-1:0]  ex_rd;
  logic              ex_reg_write;
  logic              ex_mem_read;
  logic              ex_mem_write;
  logic [3:0]        ex_alu_op;
  logic [1:0]        ex_fwd_a_sel;
  logic [1:0]        ex_fwd_b_sel;
  logic [CNT_W-1:0]  stall_count;

  modport slave (
    input  flush, id_valid, id_rs, id_rt, id_rd, id_rs_data, id_rt_data, id_imm,
           id_alusrc, id_uses_rt, id_reg_write, id_mem_read, id_mem_write, id_alu_op,
           mem_rd, mem_reg_write,
    output stall, ex_valid, ex_rs_data, ex_rt_data, ex_imm, ex_rd, ex_reg_write,
           ex_mem_read, ex_mem_write, ex_alu_op, ex_fwd_a_sel, ex_fwd_b_sel, stall_count
  );

  modport master (
    output flush, id_valid, id_rs, id_rt, id_rd, id_rs_data, id_rt_data, id_imm,
           id_alusrc, id_uses_rt, id_reg_write, id_mem_read, id_mem_write, id_alu_op,
           mem_rd, mem_reg_write,
    input  stall, ex_valid, ex_rs_data, ex_rt_data, ex_imm, ex_rd, ex_reg_write,
           ex_mem_read, ex_mem_write, ex_alu_op, ex_fwd_a_sel, ex_fwd_b_sel, stall_count
  );
endinterface

// File: rtl/id_ex_fwd_stage.sv
// ID/EX pipeline register with load-use bubble insertion and pre-registered
// forwarding selects for the two EX operand muxes.
module id_ex_fwd_stage #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned REG_W  = 5,
  parameter int unsigned CNT_W  = 16
) (
  input logic           clk,
  input logic           rst,
  id_ex_fwd_stage_if.slave bus_io
);

  localparam logic [1:0] SelReg   = 2'b00;
  localparam logic [1:0] SelExMem = 2'b01;
  localparam logic [1:0] SelMemWb = 2'b10;
  localparam logic [1:0] SelImm   = 2'b11;

  logic              ex_valid_q, ex_valid_d;
  logic [DATA_W-1:0] ex_rs_data_q, ex_rs_data_d;
  logic [DATA_W-1:0] ex_rt_data_q, ex_rt_data_d;
  logic [DATA_W-1:0] ex_imm_q, ex_imm_d;
  logic [REG_W-1:0]  ex_rd_q, ex_rd_d;
  logic              ex_reg_write_q, ex_reg_write_d;
  logic              ex_mem_read_q, ex_mem_read_d;
  logic              ex_mem_write_q, ex_mem_write_d;
  logic [3:0]        ex_alu_op_q, ex_alu_op_d;
  logic [1:0]        fwd_a_sel_q, fwd_a_sel_d;
  logic [1:0]        fwd_b_sel_q, fwd_b_sel_d;
  logic [CNT_W-1:0]  stall_count_q, stall_count_d;

  logic ex_wr_nz, mem_wr_nz;
  logic hit_a_ex, hit_b_ex, hit_a_mem, hit_b_mem;
  logic lu;

  // Hazard detection against the instruction now in EX and the one in MEM; $0 is never a producer.
  always_comb begin
    ex_wr_nz  = ex_valid_q & ex_reg_write_q & (ex_rd_q != '0);
    mem_wr_nz = bus_io.mem_reg_write & (bus_io.mem_rd != '0);
    hit_a_ex  = ex_wr_nz & (ex_rd_q == bus_io.id_rs);
    hit_b_ex  = ex_wr_nz & (ex_rd_q == bus_io.id_rt);
    hit_a_mem = mem_wr_nz & (bus_io.mem_rd == bus_io.id_rs);
    hit_b_mem = mem_wr_nz & (bus_io.mem_rd == bus_io.id_rt);
    lu = bus_io.id_valid & ex_valid_q & ex_mem_read_q & (ex_rd_q != '0) &
         ((ex_rd_q == bus_io.id_rs) | (bus_io.id_uses_rt & (ex_rd_q == bus_io.id_rt)));
  end

  // Next EX contents: flush beats load-use bubble beats a normal latch of the ID fields.
  always_comb begin
    ex_valid_d     = 1'b0;
    ex_rs_data_d   = '0;
    ex_rt_data_d   = '0;
    ex_imm_d       = '0;
    ex_rd_d        = '0;
    ex_reg_write_d = 1'b0;
    ex_mem_read_d  = 1'b0;
    ex_mem_write_d = 1'b0;
    ex_alu_op_d    = '0;
    fwd_a_sel_d    = SelReg;
    fwd_b_sel_d    = SelReg;
    stall_count_d  = stall_count_q;

    if (bus_io.flush) begin
      // Bubble only; the counter tracks load-use bubbles, not squashes.
    end else if (lu) begin
      if (stall_count_q != '1) begin
        stall_count_d = stall_count_q + CNT_W'(1);
      end
    end else begin
      ex_valid_d     = bus_io.id_valid;
      ex_rs_data_d   = bus_io.id_rs_data;
      ex_rt_data_d   = bus_io.id_rt_data;
      ex_imm_d       = bus_io.id_imm;
      ex_rd_d        = bus_io.id_rd;
      ex_reg_write_d = bus_io.id_valid & bus_io.id_reg_write;
      ex_mem_read_d  = bus_io.id_valid & bus_io.id_mem_read;
      ex_mem_write_d = bus_io.id_valid & bus_io.id_mem_write;
      ex_alu_op_d    = bus_io.id_alu_op;
      // The EX/MEM producer is younger than MEM/WB, so it takes priority.
      if (hit_a_ex) begin
        fwd_a_sel_d = SelExMem;
      end else if (hit_a_mem) begin
        fwd_a_sel_d = SelMemWb;
      end
      if (bus_io.id_alusrc) begin
        fwd_b_sel_d = SelImm;
      end else if (hit_b_ex) begin
        fwd_b_sel_d = SelExMem;
      end else if (hit_b_mem) begin
        fwd_b_sel_d = SelMemWb;
      end
    end
  end

  // Pipeline register with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      ex_valid_q     <= 1'b0;
      ex_rs_data_q   <= '0;
      ex_rt_data_q   <= '0;
      ex_imm_q       <= '0;
      ex_rd_q        <= '0;
      ex_reg_write_q <= 1'b0;
      ex_mem_read_q  <= 1'b0;
      ex_mem_write_q <= 1'b0;
      ex_alu_op_q    <= '0;
      fwd_a_sel_q    <= SelReg;
      fwd_b_sel_q    <= SelReg;
      stall_count_q  <= '0;
    end else begin
      ex_valid_q     <= ex_valid_d;
      ex_rs_data_q   <= ex_rs_data_d;
      ex_rt_data_q   <= ex_rt_data_d;
      ex_imm_q       <= ex_imm_d;
      ex_rd_q        <= ex_rd_d;
      ex_reg_write_q <= ex_reg_write_d;
      ex_mem_read_q  <= ex_mem_read_d;
      ex_mem_write_q <= ex_mem_write_d;
      ex_alu_op_q    <= ex_alu_op_d;
      fwd_a_sel_q    <= fwd_a_sel_d;
      fwd_b_sel_q    <= fwd_b_sel_d;
      stall_count_q  <= stall_count_d;
    end
  end

  // Outputs come straight from registers, except the stall request.
  always_comb begin
    bus_io.stall        = lu & ~bus_io.flush & ~rst;
    bus_io.ex_valid     = ex_valid_q;
    bus_io.ex_rs_data   = ex_rs_data_q;
    bus_io.ex_rt_data   = ex_rt_data_q;
    bus_io.ex_imm       = ex_imm_q;
    bus_io.ex_rd        = ex_rd_q;
    bus_io.ex_reg_write = ex_reg_write_q;
    bus_io.ex_mem_read  = ex_mem_read_q;
    bus_io.ex_mem_write = ex_mem_write_q;
    bus_io.ex_alu_op    = ex_alu_op_q;
    bus_io.ex_fwd_a_sel = fwd_a_sel_q;
    bus_io.ex_fwd_b_sel = fwd_b_sel_q;
    bus_io.stall_count  = stall_count_q;
  end

endmodule

// File: tb/tb_id_ex_fwd_stage.sv
// Directed bench for id_ex_fwd_stage: forwarding selects, load-use bubbles, flush, saturation.
module tb_id_ex_fwd_stage;

  logic clk;
  logic rst;
  int   n_pass;
  int   n_total;

  id_ex_fwd_stage_if #(.DATA_W(32), .REG_W(5), .CNT_W(16)) bus ();
  id_ex_fwd_stage_if #(.DATA_W(32), .REG_W(5), .CNT_W(2))  bus2 ();

  id_ex_fwd_stage #(.DATA_W(32), .REG_W(5), .CNT_W(16)) dut (
    .clk    (clk),
    .rst    (rst),
    .bus_io (bus)
  );

  id_ex_fwd_stage #(.DATA_W(32), .REG_W(5), .CNT_W(2)) dut_sat (
    .clk    (clk),
    .rst    (rst),
    .bus_io (bus2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Present one decoded instruction on the main DUT's ID side.
  task automatic drive(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                       input logic [4:0] rd, input logic [31:0] imm, input logic alusrc,
                       input logic uses_rt, input logic rw, input logic mr, input logic mw);
    bus.id_valid     = v;
    bus.id_rs        = rs;
    bus.id_rt        = rt;
    bus.id_rd        = rd;
    bus.id_rs_data   = 32'hA000_0000 | {27'd0, rs};
    bus.id_rt_data   = 32'hB000_0000 | {27'd0, rt};
    bus.id_imm       = imm;
    bus.id_alusrc    = alusrc;
    bus.id_uses_rt   = uses_rt;
    bus.id_reg_write = rw;
    bus.id_mem_read  = mr;
    bus.id_mem_write = mw;
    bus.id_alu_op    = rd[3:0];
  endtask

  task automatic mem(input logic [4:0] rd, input logic rw);
    bus.mem_rd        = rd;
    bus.mem_reg_write = rw;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic nop();
    drive(1'b1, 5'd0, 5'd0, 5'd0, 32'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    mem(5'd0, 1'b0);
    step();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      bus.flush = 1'($urandom);
      drive(1'($urandom), 5'($urandom), 5'($urandom), 5'($urandom), $urandom, 1'($urandom),
            1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
      mem(5'($urandom), 1'($urandom));
      #1;
      n_total++;
      if (bus.stall !== 1'b0) $display("FAIL reset_stall[%0d]: got %b want 0", i, bus.stall);
      else n_pass++;
      step();
    end
    n_total++;
    if (bus.ex_valid !== 1'b0) $display("FAIL reset_ex_valid: got %b want 0", bus.ex_valid);
    else n_pass++;
    n_total++;
    if ({bus.ex_reg_write, bus.ex_mem_read, bus.ex_mem_write} !== 3'b000)
      $display("FAIL reset_ctrl: got %b want 000",
               {bus.ex_reg_write, bus.ex_mem_read, bus.ex_mem_write});
    else n_pass++;
    n_total++;
    if ({bus.ex_rs_data, bus.ex_rt_data, bus.ex_imm} !== 96'd0)
      $display("FAIL reset_data: got %h %h %h want 0", bus.ex_rs_data, bus.ex_rt_data,
               bus.ex_imm);
    else n_pass++;
    n_total++;
    if ({bus.ex_rd, bus.ex_alu_op} !== 9'd0)
      $display("FAIL reset_rd_op: got %h %h want 0", bus.ex_rd, bus.ex_alu_op);
    else n_pass++;
    n_total++;
    if ({bus.ex_fwd_a_sel, bus.ex_fwd_b_sel} !== 4'b0000)
      $display("FAIL reset_sel: got %b %b want 00 00", bus.ex_fwd_a_sel, bus.ex_fwd_b_sel);
    else n_pass++;
    n_total++;
    if (bus.stall_count !== 16'd0) $display("FAIL reset_count: got %0d want 0", bus.stall_count);
    else n_pass++;
    n_total++;
    if (bus2.stall_count !== 2'd0) $display("FAIL reset_count2: got %0d want 0", bus2.stall_count);
    else n_pass++;
    rst = 1'b0;
    bus.flush = 1'b0;
    nop();
  endtask

  task automatic test_ex_fwd();
    // add $3,$1,$2 ; sub $4,$3,$5
    drive(1'b1, 5'd1, 5'd2, 5'd3, 32'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    mem(5'd0, 1'b0);
    step();
    drive(1'b1, 5'd3, 5'd5, 5'd4, 32'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    step();
    n_total++;
    if ({bus.ex_fwd_a_sel, bus.ex_fwd_b_sel} !== 4'b0100)
      $display("FAIL ex_fwd_sel: got %b %b want 01 00", bus.ex_fwd_a_sel, bus.ex_fwd_b_sel);
    else n_pass++;
    n_total++;
    if ({bus.ex_valid, bus.ex_rd, bus.ex_reg_write, bus.ex_alu_op} !== {1'b1, 5'd4, 1'b1, 4'd4})
      $display("FAIL ex_fwd_ctrl: got v=%b rd=%0d rw=%b op=%0d want 1 4 1 4", bus.ex_valid,
               bus.ex_rd, bus.ex_reg_write, bus.ex_alu_op);
    else n_pass++;
    n_total++;
    if ({bus.ex_rs_data, bus.ex_rt_data} !== {32'hA000_0003, 32'hB000_0005})
      $display("FAIL ex_fwd_data: got %h %h want a0000003 b0000005", bus.ex_rs_data,
               bus.ex_rt_data);
    else n_pass++;
    // add $0,$1,$2 ; sub $4,$0,$5 with MEM also writing $0
    drive(1'b1, 5'd1, 5'd2, 5'd0, 32'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    step();
    drive(1'b1, 5'd0, 5'd5, 5'd4, 32'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    mem(5'd0, 1'b1);
    step();
    n_total++;
    if ({bus.ex_fwd_a_sel, bus.ex_fwd_b_sel} !== 4'b0000)
      $display("FAIL zero_reg_sel: got %b %b want 00 00", bus.ex_fwd_a_sel, bus.ex_fwd_b_sel);
    else n_pass++;
    nop();
  endtask

  task automatic test_mem_fwd();
    // add $3 ; nop ; or $6,$3,$3
    drive(1'b1, 5'd1, 5'd2, 5'd3, 32'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    step();
    nop();
    drive(1'b1, 5'd3, 5'd3, 5'd6, 32'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    mem(5'd3, 1'b1);
    step();
    n_total++;
    if ({bus.ex_fwd_a_sel, bus.ex_fwd_b_sel} !== 4'b1010)
      $display("FAIL mem_fwd_sel: got %b %b want 10 10", bus.ex_fwd_a_sel, bus.ex_fwd_b_sel);
    else n_pass++;
    // add $3 ; add $3 ; and $7,$3,$2
    drive(1'b1, 5'd1, 5'd2, 5'd3, 32'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    mem(5'd0, 1'b0);
    step();
    drive(1'b1, 5'd1, 5'd2, 5'd3, 32'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    step();
    drive(1'b1, 5'd3, 5'd2, 5'd7, 32'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    mem(5'd3, 1'b1);
    step();
    n_total++;
    if ({bus.ex_fwd_a_sel, bus.ex_fwd_b_sel} !== 4'b0100)
      $display("FAIL priority_sel: got %b %b want 01 00", bus.ex_fwd_a_sel, bus.ex_fwd_b_sel);
    else n_pass++;
    nop();
  endtask

  task automatic test_load_use();
    // lw $2,0($1) ; add $4,$2,$2
    drive(1'b1, 5'd1, 5'd2, 5'd2, 32'd0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
    step();
    drive(1'b1, 5'd2, 5'd2, 5'd4, 32'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    #1;
    n_total++;
    if (bus.stall !== 1'b1) $display("FAIL lu_stall: got %b want 1", bus.stall);
    else n_pass++;
    step();
    n_total++;
    if ({bus.ex_valid, bus.ex_mem_read, bus.ex_reg_write} !== 3'b000)
      $display("FAIL lu_bubble: got v=%b mr=%b rw=%b want 0 0 0", bus.ex_valid,
               bus.ex_mem_read, bus.ex_reg_write);
    else n_pass++;
    n_total++;
    if (bus.stall_count !== 16'd1) $display("FAIL lu_count: got %0d want 1", bus.stall_count);
    else n_pass++;
    mem(5'd2, 1'b1);
    #1;
    n_total++;
    if (bus.stall !== 1'b0) $display("FAIL lu_stall_once: got %b want 0", bus.stall);
    else n_pass++;
    step();
    n_total++;
    if ({bus.ex_valid, bus.ex_rd, bus.ex_fwd_a_sel, bus.ex_fwd_b_sel} !==
        {1'b1, 5'd4, 2'b10, 2'b10})
      $display("FAIL lu_resume: got v=%b rd=%0d sel=%b %b want 1 4 10 10", bus.ex_valid,
               bus.ex_rd, bus.ex_fwd_a_sel, bus.ex_fwd_b_sel);
    else n_pass++;
    nop();
  endtask

  task automatic test_imm_flush();
    // add $3 ; addi $5,$3,7
    drive(1'b1, 5'd1, 5'd2, 5'd3, 32'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    step();
    drive(1'b1, 5'd3, 5'd5, 5'd5, 32'd7, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    step();
    n_total++;
    if ({bus.ex_fwd_a_sel, bus.ex_fwd_b_sel, bus.ex_imm} !== {2'b01, 2'b11, 32'd7})
      $display("FAIL imm_sel: got %b %b imm=%0d want 01 11 7", bus.ex_fwd_a_sel,
               bus.ex_fwd_b_sel, bus.ex_imm);
    else n_pass++;
    // lw $2 ; add $4,$2,$2 squashed by flush in the load-use cycle
    drive(1'b1, 5'd1, 5'd2, 5'd2, 32'd0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
    step();
    drive(1'b1, 5'd2, 5'd2, 5'd4, 32'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    bus.flush = 1'b1;
    #1;
    n_total++;
    if (bus.stall !== 1'b0) $display("FAIL flush_stall: got %b want 0", bus.stall);
    else n_pass++;
    step();
    bus.flush = 1'b0;
    n_total++;
    if ({bus.ex_valid, bus.ex_reg_write, bus.ex_fwd_a_sel} !== 4'b0000)
      $display("FAIL flush_bubble: got v=%b rw=%b sel=%b want 0 0 00", bus.ex_valid,
               bus.ex_reg_write, bus.ex_fwd_a_sel);
    else n_pass++;
    n_total++;
    if (bus.stall_count !== 16'd1) $display("FAIL flush_count: got %0d want 1", bus.stall_count);
    else n_pass++;
    // Invalid ID slot: control bits must not reach EX.
    drive(1'b0, 5'd1, 5'd2, 5'd9, 32'd0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1);
    step();
    n_total++;
    if ({bus.ex_valid, bus.ex_reg_write, bus.ex_mem_read, bus.ex_mem_write} !== 4'b0000)
      $display("FAIL invalid_ctrl: got %b want 0000",
               {bus.ex_valid, bus.ex_reg_write, bus.ex_mem_read, bus.ex_mem_write});
    else n_pass++;
  endtask

  task automatic test_saturation();
    logic [1:0] want;
    for (int i = 0; i < 5; i++) begin
      // lw $2,0($1)
      bus2.id_valid = 1'b1; bus2.id_rs = 5'd1; bus2.id_rt = 5'd2; bus2.id_rd = 5'd2;
      bus2.id_alusrc = 1'b1; bus2.id_uses_rt = 1'b0;
      bus2.id_reg_write = 1'b1; bus2.id_mem_read = 1'b1;
      step();
      // add $4,$2,$2 -> stalls
      bus2.id_rs = 5'd2; bus2.id_rt = 5'd2; bus2.id_rd = 5'd4;
      bus2.id_alusrc = 1'b0; bus2.id_uses_rt = 1'b1; bus2.id_mem_read = 1'b0;
      step();
      want = (i >= 2) ? 2'd3 : 2'(i + 1);
      n_total++;
      if (bus2.stall_count !== want)
        $display("FAIL sat_count[%0d]: got %0d want %0d", i, bus2.stall_count, want);
      else n_pass++;
    end
  endtask

  initial begin
    n_pass  = 0;
    n_total = 0;
    rst     = 1'b1;
    bus.flush = 1'b0;
    bus2.flush = 1'b0; bus2.id_valid = 1'b0; bus2.id_rs = '0; bus2.id_rt = '0;
    bus2.id_rd = '0; bus2.id_rs_data = '0; bus2.id_rt_data = '0; bus2.id_imm = '0;
    bus2.id_alusrc = 1'b0; bus2.id_uses_rt = 1'b0; bus2.id_reg_write = 1'b0;
    bus2.id_mem_read = 1'b0; bus2.id_mem_write = 1'b0; bus2.id_alu_op = '0;
    bus2.mem_rd = '0; bus2.mem_reg_write = 1'b0;
    test_reset();
    test_ex_fwd();
    test_mem_fwd();
    test_load_use();
    test_imm_flush();
    test_saturation();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/id_ex_fwd_stage.md
Name: id_ex_fwd_stage

Overview:
- ID/EX pipeline register for the 5-stage MIPS core.
- Latches decoded operands and control from ID.
- Detects load-use hazards and inserts a one-cycle bubble plus IF/ID stall.
- Precomputes registered 2-bit select codes for the two EX-stage 4:1 ALU-operand muxes (00 regfile, 01 EX/MEM result, 10 MEM/WB result, 11 immediate) so the muxes see stable selects at the start of EX.

Parameters:
- DATA_W, 32, operand/immediate width
- REG_W, 5, register-specifier width
- CNT_W, 16, stall-counter width

Ports:
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- flush  in  1  branch-taken/squash: convert ID instruction to bubble
- id_valid  in  1  ID holds a real instruction
- id_rs  in  REG_W  source register A
- id_rt  in  REG_W  source register B
- id_rd  in  REG_W  destination register, already resolved rt/rd
- id_rs_data  in  DATA_W  regfile read A
- id_rt_data  in  DATA_W  regfile read B
- id_imm  in  DATA_W  sign-extended immediate
- id_alusrc  in  1  operand B is immediate
- id_uses_rt  in  1  instruction reads rt as a source (R-type, store, beq)
- id_reg_write  in  1  writes a register
- id_mem_read  in  1  is a load
- id_mem_write  in  1  is a store
- id_alu_op  in  4  ALU operation code
- mem_rd  in  REG_W  destination of the instruction currently in MEM
- mem_reg_write  in  1  MEM instruction writes a register
- stall  out  1  hold PC and IF/ID (combinational)
- ex_valid  out  1  EX holds a real instruction
- ex_rs_data, ex_rt_data, ex_imm  out  DATA_W  latched operands
- ex_rd  out  REG_W  latched destination
- ex_reg_write, ex_mem_read, ex_mem_write  out  1  latched control
- ex_alu_op  out  4  latched ALU op
- ex_fwd_a_sel  out  2  select for operand-A mux
- ex_fwd_b_sel  out  2  select for operand-B mux
- stall_count  out  CNT_W  load-use bubbles inserted since reset

Behaviour:
- Reset (rst=1 at edge): all ex_* outputs 0, both selects 2'b00, stall_count 0. stall reads 0 while rst=1. Reset mid-stall discards the held instruction; the IF/ID owner handles its own reset.
- Producer definitions:
  - hitA_ex = ex_valid & ex_reg_write & ex_rd!=0 & ex_rd==id_rs; hitB_ex is the same with id_rt.
  - hitA_mem = mem_reg_write & mem_rd!=0 & mem_rd==id_rs; hitB_mem likewise.
- Load-use: lu = id_valid & ex_valid & ex_mem_read & ex_rd!=0 & (ex_rd==id_rs | (id_uses_rt & ex_rd==id_rt)).
- stall = lu & ~flush & ~rst, combinational.
- Register update each edge, priority rst > flush > lu > normal:
  - flush: bubble. ex_valid=0, reg_write/mem_read/mem_write=0, selects 00. Data fields don't-care; tie to 0.
  - lu: bubble as above; stall_count += 1, saturating at all-ones.
  - Normal: latch all id_* fields; ex_valid=id_valid. If id_valid=0, control bits are forced 0.
- Select encoding, registered in the normal case:
  - ex_fwd_a_sel = 01 if hitA_ex, else 10 if hitA_mem, else 00. EX/MEM wins over MEM/WB because it is the younger producer.
  - ex_fwd_b_sel = 11 if id_alusrc (immediate overrides forwarding), else 01 if hitB_ex, else 10 if hitB_mem, else 00.
  - Store data forwarding on rt when alusrc=1 is out of scope for this block.
- Latency:
  - One cycle ID→EX.
  - A load-use dependency costs exactly one bubble. The next cycle the load sits in MEM, lu clears, and the consumer gets sel 10 via mem_rd.
- Register $0 never forwards and never stalls.
- No combinational path from any id_* input to any ex_* output.

Test Plan:
- Reset: hold rst 2 cycles with random inputs → all ex_* = 0, selects 00, stall=0, stall_count=0.
- EX forward: add $3 then sub $4,$3,$5 back-to-back → sub in EX with ex_fwd_a_sel=01, ex_fwd_b_sel=00. Same with $0 as destination → selects 00.
- MEM forward and priority:
  - add $3; nop; or $6,$3,$3 → both selects 10.
  - add $3; add $3; and $7,$3,$2 → sel A=01, because the younger producer wins.
- Load-use: lw $2,0($1); add $4,$2,$2 → stall=1 for exactly 1 cycle, bubble (ex_valid=0) enters EX, stall_count=1. Next cycle add enters EX with both selects 10.
- Immediate and flush:
  - addi $5,$3,7 after add $3 → sel B=11, sel A=01.
  - Assert flush during a load-use cycle → bubble, stall=0, stall_count unchanged.
- Counter saturation: set CNT_W=2, create 5 load-use stalls → stall_count stays 3.
